// File: rtl/oa22_stim_arbiter.sv
// oa22_stim_arbiter: round-robin sharing of one OA22 cell under test, with settle-timed sampling and a toggle-activity count.
module oa22_stim_arbiter #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CW         = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [4*NREQ-1:0] VEC,
    input  logic              CLR_CNT,
    input  logic              Q,
    output logic              IN1,
    output logic              IN2,
    output logic              IN3,
    output logic              IN4,
    output logic [NREQ-1:0]   ACK,
    output logic              RES,
    output logic              BUSY,
    output logic [CW-1:0]     TOGCNT
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, ACKS = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, g_q, g_d, sel;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      vec_q, vec_d, vsel;
    logic [NREQ-1:0] ack_q, ack_d, rq;
    logic            res_q, res_d, busy_q, busy_d, found;
    logic [CW-1:0]   tog_q, tog_d;
    int              p;

    always_comb begin
        found = 1'b0;
        sel = '0;
        vsel = '0;
        p = 0;
        rq = '0;
        // Walk downward so the requester closest to ptr (smallest offset) wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            p = int'(ptr_q) + k;
            if (p >= NREQ) p = p - NREQ;
            rq = REQ >> p;
            if (rq[0]) begin
                found = 1'b1;
                sel = IW'(p);
                vsel = 4'(VEC >> (4 * p));
            end
        end
        state_d = state_q;
        ptr_d = ptr_q;
        g_d = g_q;
        cnt_d = cnt_q;
        vec_d = vec_q;
        ack_d = '0;
        res_d = res_q;
        busy_d = busy_q;
        tog_d = tog_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = SETTLE;
                vec_d = vsel;
                cnt_d = 8'(SETTLE_CYC);
                g_d = sel;
                busy_d = 1'b1;
            end
            SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ACKS;
                    res_d = Q;
                    ack_d = NREQ'(1) << g_q;
                    ptr_d = g_q == IW'(NREQ - 1) ? '0 : g_q + IW'(1);
                    tog_d = (Q != res_q && tog_q != '1) ? tog_q + CW'(1) : tog_q;
                end
            end
            ACKS: begin
                state_d = IDLE;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (CLR_CNT) tog_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q <= '0;
            g_q <= '0;
            cnt_q <= '0;
            vec_q <= '0;
            ack_q <= '0;
            res_q <= 1'b0;
            busy_q <= 1'b0;
            tog_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            g_q <= g_d;
            cnt_q <= cnt_d;
            vec_q <= vec_d;
            ack_q <= ack_d;
            res_q <= res_d;
            busy_q <= busy_d;
            tog_q <= tog_d;
        end
    end

    assign {IN4, IN3, IN2, IN1} = vec_q;
    assign ACK = ack_q;
    assign RES = res_q;
    assign BUSY = busy_q;
    assign TOGCNT = tog_q;
endmodule

// File: tb/tb_oa22_stim_arbiter.sv
// tb_oa22_stim_arbiter: scoreboard bench for the OA22 stimulus arbiter with a behavioural cell on Q.
module tb_oa22_stim_arbiter;
    localparam int SC = 2;

    typedef struct packed {
        logic [3:0] ack;
        logic       res;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, clr_cnt = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] vec = '0;
    logic        q, in1, in2, in3, in4, res, busy;
    logic [3:0]  ack;
    logic [2:0]  togcnt;
    int          checks = 0, failures = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    assign q = (in1 | in2) & (in3 | in4);

    oa22_stim_arbiter #(.NREQ(4), .SETTLE_CYC(SC), .CW(3)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .VEC(vec), .CLR_CNT(clr_cnt), .Q(q),
        .IN1(in1), .IN2(in2), .IN3(in3), .IN4(in4),
        .ACK(ack), .RES(res), .BUSY(busy), .TOGCNT(togcnt)
    );

    function automatic logic oa22(input logic [3:0] v);
        return (v[0] | v[1]) & (v[2] | v[3]);
    endfunction

    function automatic logic [3:0] slice(input logic [15:0] v, input int i);
        return 4'(v >> (4 * i));
    endfunction

    task automatic push(input logic [3:0] a, input logic r);
        exp_t e;
        e.ack = a;
        e.res = r;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ack !== 4'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack got=%b want=none", ack);
            end else begin
                e = sb.pop_front();
                checks++;
                if (ack !== e.ack) begin
                    failures++;
                    $display("FAIL ack_order got=%b want=%b", ack, e.ack);
                end
                checks++;
                if (res !== e.res) begin
                    failures++;
                    $display("FAIL ack_res got=%b want=%b", res, e.res);
                end
            end
        end
    end

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (ack === 4'b0 && cycles < 40);
        if (ack === 4'b0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout got=none want=ack within 40 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        req = 4'b1111;
        vec = 16'hC615;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({in1, in2, in3, in4, ack, res, busy, togcnt} !== 13'b0) begin
                failures++;
                $display("FAIL reset_outputs got=%b want=0", {in1, in2, in3, in4, ack, res, busy, togcnt});
            end
        end
        rst = 1'b0;
        push(4'b0001, oa22(slice(vec, 0)));
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {in4, in3, in2, in1} !== slice(vec, 0)) begin
            failures++;
            $display("FAIL first_grant got busy=%b in=%b want busy=1 in=%b", busy, {in4, in3, in2, in1}, slice(vec, 0));
        end
        wait_ack(c);
        checks++;
        if (c != SC) begin
            failures++;
            $display("FAIL first_ack_latency got=%0d want=%0d", c, SC);
        end
    endtask

    task automatic test_round_robin();
        int ord[8] = '{1, 2, 3, 0, 1, 3, 1, 3};
        int c;
        for (int i = 0; i < 8; i++) begin
            push(4'(1 << ord[i]), oa22(slice(vec, ord[i])));
            wait_ack(c);
            checks++;
            if (c != SC + 2) begin
                failures++;
                $display("FAIL rr_period[%0d] got=%0d want=%0d", i, c, SC + 2);
            end
            if (i == 3) begin
                req[0] = 1'b0;
                req[2] = 1'b0;
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c;
        do_reset();
        vec = '0;
        vec[7:4] = 4'b0101;
        req = 4'b0010;
        push(4'b0010, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {in1, in2, in3, in4} !== 4'b1010) begin
            failures++;
            $display("FAIL single_inputs got busy=%b in1..4=%b want busy=1 in1..4=1010", busy, {in1, in2, in3, in4});
        end
        wait_ack(c);
        checks++;
        if (c != SC) begin
            failures++;
            $display("FAIL single_latency got=%0d want=%0d", c, SC);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (res !== 1'b1 || togcnt !== 3'd1 || busy !== 1'b0 || ack !== 4'b0) begin
            failures++;
            $display("FAIL single_after got res=%b tog=%0d busy=%b ack=%b want res=1 tog=1 busy=0 ack=0", res, togcnt, busy, ack);
        end
        checks++;
        if ({in1, in2, in3, in4} !== 4'b1010) begin
            failures++;
            $display("FAIL single_hold got=%b want=1010", {in1, in2, in3, in4});
        end
    endtask

    task automatic test_sweep();
        int c;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++;
        if (togcnt !== 3'd0 || res !== 1'b1) begin
            failures++;
            $display("FAIL clr_idle got tog=%0d res=%b want tog=0 res=1", togcnt, res);
        end
        for (int v = 0; v < 16; v++) begin
            vec[15:12] = 4'(v);
            req[3] = 1'b1;
            push(4'b1000, oa22(4'(v)));
            wait_ack(c);
            req[3] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (togcnt !== 3'd6) begin
            failures++;
            $display("FAIL sweep_togcnt got=%0d want=6", togcnt);
        end
    endtask

    task automatic test_counter();
        int c;
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = (i % 2 == 0) ? 4'hF : 4'h0;
            vec[3:0] = v;
            req[0] = 1'b1;
            push(4'b0001, oa22(v));
            wait_ack(c);
            req[0] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (togcnt !== 3'd7) begin
            failures++;
            $display("FAIL cnt_saturate got=%0d want=7", togcnt);
        end
        vec[3:0] = 4'hF;
        req[0] = 1'b1;
        push(4'b0001, 1'b1);
        repeat (2) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        req[0] = 1'b0;
        checks++;
        if (togcnt !== 3'd0) begin
            failures++;
            $display("FAIL clr_beats_inc got=%0d want=0", togcnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        vec[11:8] = 4'hF;
        req = 4'b0100;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0 || {in1, in2, in3, in4} !== 4'b0 || busy !== 1'b0 || res !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got ack=%b in=%b busy=%b res=%b want all 0", ack, {in1, in2, in3, in4}, busy, res);
        end
        rst = 1'b0;
        push(4'b0100, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {in1, in2, in3, in4} !== 4'b1111) begin
            failures++;
            $display("FAIL regrant got busy=%b in=%b want busy=1 in=1111", busy, {in1, in2, in3, in4});
        end
        wait_ack(c);
        checks++;
        if (c != SC) begin
            failures++;
            $display("FAIL regrant_latency got=%0d want=%0d", c, SC);
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_sweep();
        test_counter();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
